// File: rtl/controlador_display.sv
// controlador_display
//   Time-multiplexed scan controller for a bank of 7-segment digits that
//   share one BCD-to-7-segment decoder. Each digit is lit for DIV cycles and
//   followed by GUARD dead-time cycles with every enable off. A new value is
//   staged in a shadow register and only copied into the displayed register
//   at a frame boundary, so a half-updated number is never shown.
//
//   Ports
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset
//     load       : request to capture valor
//     ready      : high when a new value can be accepted (no value pending)
//     valor      : N_DIGITS packed BCD digits, digit 0 in valor[3:0]
//     blank_lz   : leading-zero suppression enable, used live
//     codigo     : BCD code for the shared decoder
//     anodo      : one-hot active-high digit enable
//     frame      : one-cycle pulse on the first lit cycle of digit 0
//     dbg_state  : current scan state (0 = SHOW, 1 = GUARD)
//
//   Handshake: a transfer happens on a rising edge where load=1 and ready=1;
//   ready then stays low until the staged value is committed at the next
//   frame boundary. load while ready=0 has no effect.
module controlador_display #(
   parameter int N_DIGITS = 4,
   parameter int DIV      = 50000,
   parameter int GUARD    = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   output logic                    ready,
   input  logic [4*N_DIGITS-1:0]   valor,
   input  logic                    blank_lz,
   output logic [3:0]              codigo,
   output logic [N_DIGITS-1:0]     anodo,
   output logic                    frame,
   output logic                    dbg_state
);

   localparam int MAXC  = (DIV > GUARD) ? DIV : GUARD;
   localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   typedef enum logic {
      ST_SHOW  = 1'b0,
      ST_GUARD = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [4*N_DIGITS-1:0]   disp_q;
   logic [4*N_DIGITS-1:0]   shadow_q;
   logic                    pending_q;

   logic                    boundary;
   logic                    xfer;
   logic [N_DIGITS-1:0]     supp;
   logic                    all_zero;
   logic                    lit;

   // Next-state logic for the scan FSM
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 1'b1;
      case (state_q)
         ST_SHOW: begin
            if (cnt_q == DIV_LAST) begin
               state_d = ST_GUARD;
               cnt_d   = '0;
            end
         end
         ST_GUARD: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
               idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_GUARD;
            cnt_d   = '0;
         end
      endcase
   end

   // Frame boundary: leaving the guard after the last digit.
   assign boundary = (state_q == ST_GUARD) && (cnt_q == GUARD_LAST) && (idx_q == IDX_LAST);
   assign xfer     = load & ~pending_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_GUARD;
         idx_q     <= IDX_LAST;
         cnt_q     <= '0;
         disp_q    <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         if (xfer) begin
            shadow_q <= valor;
         end
         // Commit uses the pending value from before this edge; a transfer
         // landing on the boundary edge waits for the following frame.
         if (boundary && pending_q) begin
            disp_q <= shadow_q;
         end
         if (xfer) begin
            pending_q <= 1'b1;
         end else if (boundary) begin
            pending_q <= 1'b0;
         end
      end
   end

   // Digit i (i>=1) is a leading zero when it and every higher digit are 0.
   always_comb begin
      supp     = '0;
      all_zero = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero & (disp_q[4*i +: 4] == 4'd0);
         supp[i]  = all_zero;
      end
   end

   assign lit       = (state_q == ST_SHOW) && !(blank_lz && supp[idx_q]);
   assign anodo     = lit ? (N_DIGITS'(1) << idx_q) : '0;
   // Held through the guard so the decoder input does not glitch.
   assign codigo    = disp_q[{idx_q, 2'b00} +: 4];
   assign frame     = (state_q == ST_SHOW) && (idx_q == '0) && (cnt_q == '0);
   assign ready     = ~pending_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_controlador_display.sv
module tb_controlador_display;

   localparam int ND  = 4;
   localparam int DV  = 4;
   localparam int GD  = 1;
   localparam int SLOT  = DV + GD;
   localparam int FRAME = ND * SLOT;

   logic          clk;
   logic          rst_n;
   logic          load;
   logic          ready;
   logic [15:0]   valor;
   logic          blank_lz;
   logic [3:0]    codigo;
   logic [3:0]    anodo;
   logic          frame;
   logic          dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int phase    = 0;   // cycles since the last frame pulse, as seen by the bench
   logic [3:0] exp_q[$];

   controlador_display #(.N_DIGITS(ND), .DIV(DV), .GUARD(GD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .ready     (ready),
      .valor     (valor),
      .blank_lz  (blank_lz),
      .codigo    (codigo),
      .anodo     (anodo),
      .frame     (frame),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(negedge clk);
      phase = (phase + 1) % FRAME;
   endtask

   task automatic goto_phase(input int p);
      while (phase != p) cyc();
   endtask

   task automatic do_load(input logic [15:0] v);
      valor = v;
      load  = 1'b1;
      cyc();
      load  = 1'b0;
   endtask

   // Checks one whole frame starting at the frame-pulse sample; ends at the
   // next frame-pulse sample.
   task automatic check_frame(input string name, input logic [15:0] v, input logic blank);
      int d;
      logic sup;
      logic [3:0] exp_code;
      logic [3:0] exp_an;
      for (int k = 0; k < ND; k++) exp_q.push_back(v[4*k +: 4]);
      for (int c = 0; c < FRAME; c++) begin
         d = c / SLOT;
         if (c % SLOT == 0) exp_code = exp_q.pop_front();
         sup = 1'b0;
         if (blank && d >= 1) begin
            sup = 1'b1;
            for (int k = d; k < ND; k++) if (v[4*k +: 4] != 4'd0) sup = 1'b0;
         end
         exp_an = ((c % SLOT) < DV && !sup) ? (4'b0001 << d) : 4'b0000;
         chk($sformatf("%s anodo c%0d", name, c), anodo, exp_an);
         chk($sformatf("%s codigo c%0d", name, c), codigo, exp_code);
         chk($sformatf("%s frame c%0d", name, c), frame, (c == 0));
         cyc();
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      valor    = 16'h0000;
      blank_lz = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst anodo", anodo, 4'b0000);
      chk("rst codigo", codigo, 4'd0);
      chk("rst ready", ready, 1'b1);
      chk("rst frame", frame, 1'b0);

      // Release: first frame pulse one cycle later
      rst_n = 1'b1;
      cyc();
      phase = 0;
      chk("first frame", frame, 1'b1);
      chk("first anodo", anodo, 4'b0001);
      check_frame("zero", 16'h0000, 1'b0);

      // Load mid-frame, then a second load that must be ignored
      goto_phase(2);
      do_load(16'h1234);
      chk("ready after load", ready, 1'b0);
      chk("not committed yet", codigo, 4'd0);
      do_load(16'h9999);
      chk("ready still low", ready, 1'b0);
      goto_phase(0);
      chk("ready at commit", ready, 1'b1);
      check_frame("v1234", 16'h1234, 1'b0);

      // Load on the boundary edge: old value for one more frame
      goto_phase(FRAME - 1);
      do_load(16'h5678);
      chk("boundary ready", ready, 1'b0);
      check_frame("old kept", 16'h1234, 1'b0);
      chk("boundary commit ready", ready, 1'b1);
      check_frame("v5678", 16'h5678, 1'b0);

      // Leading-zero suppression and codes above 9
      blank_lz = 1'b1;
      goto_phase(3);
      do_load(16'h0050);
      goto_phase(0);
      check_frame("lz0050", 16'h0050, 1'b1);
      goto_phase(3);
      do_load(16'h0000);
      goto_phase(0);
      check_frame("lz0000", 16'h0000, 1'b1);
      goto_phase(3);
      do_load(16'h0A05);
      goto_phase(0);
      check_frame("lz0A05", 16'h0A05, 1'b1);
      blank_lz = 1'b0;
      goto_phase(3);
      do_load(16'hFEDC);
      goto_phase(0);
      check_frame("vFEDC", 16'hFEDC, 1'b0);

      // Reset mid-frame with a value pending
      goto_phase(3);
      do_load(16'h4321);
      chk("pending before reset", ready, 1'b0);
      goto_phase(6);
      chk("lit before reset", anodo, 4'b0010);
      #1 rst_n = 1'b0;
      #1;
      chk("async anodo", anodo, 4'b0000);
      chk("async ready", ready, 1'b1);
      chk("async codigo", codigo, 4'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      phase = 0;
      check_frame("after reset", 16'h0000, 1'b0);
      chk("ready after reset", ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/controlador_display.md
# controlador_display

Time-multiplexing scan controller for a bank of common-anode/common-cathode 7-segment digits that share a single BCD-to-7-segment decoder. The block holds a double-buffered N-digit BCD value. Each cycle it presents one digit code to the shared decoder's `entrada` input and drives the matching one-hot digit enable. It inserts a dead-time guard between digits to prevent ghosting and applies optional leading-zero suppression. New values are accepted through a load/ready handshake and committed only at frame boundaries, so a partially updated number is never displayed.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits; legal range 1..8.
- `DIV`, 50000: cycles each digit is lit per visit; must be ≥1.
- `GUARD`, 500: dead-time cycles between digits with all enables off; must be ≥1.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: reset; asynchronous, active-low.
- `load` input, 1: request to capture `valor`.
- `ready` output, 1: high when a new value can be accepted.
- `valor` input, 4*N_DIGITS: BCD digits; digit i is `valor[4i+3:4i]`, and digit 0 is the least significant.
- `blank_lz` input, 1: enables leading-zero suppression. Sampled live.
- `codigo` output, 4: BCD code routed to the shared decoder's `entrada`.
- `anodo` output, N_DIGITS: one-hot digit enable, active-high; bit i lights digit i.
- `frame` output, 1: one-cycle pulse on entry to SHOW for digit 0.

## Operation
- Registers:
  - `state` ∈ {SHOW, GUARD}.
  - `idx` (digit index).
  - `cnt` (slot counter, wide enough for max(DIV,GUARD)-1).
  - `disp` (displayed value).
  - `shadow` (staged value).
  - `pending` (a staged value is waiting to be committed).
- Outputs are Moore outputs decoded from registered state only. There is no combinational path from inputs to outputs, except `blank_lz` into `anodo`.
- SHOW:
  - `anodo` = one-hot(`idx`) unless the digit is suppressed, in which case `anodo` = 0.
  - `codigo` = `disp` digit `idx`.
  - On `cnt`==DIV-1: go to GUARD and set `cnt`=0. Otherwise increment `cnt`.
- GUARD:
  - `anodo` = 0, and `codigo` holds the last shown digit.
  - On `cnt`==GUARD-1: go to SHOW, set `cnt`=0, and set `idx` = (`idx`==N_DIGITS-1) ? 0 : `idx`+1.
- Frame boundary: the GUARD→SHOW transition where the new `idx` is 0.
  - `frame` is high for the first SHOW cycle of digit 0.
  - If `pending` was set before this edge: `disp`←`shadow`, `pending`←0.
- Handshake:
  - `ready` = ~`pending`.
  - A `load` with `ready`=1 is a transfer: `shadow`←`valor` and `pending`←1, so `ready` falls on the next cycle.
  - `load` while `ready`=0 is ignored; `shadow` is unchanged.
- Simultaneous transfer and frame boundary: the transfer fills `shadow` and sets `pending`, but the commit at that same edge uses the old `pending` value. The new value is therefore committed at the next boundary, one frame later.
- Leading-zero suppression: digit i (i≥1) is suppressed when `blank_lz`=1 and every `disp` digit from N_DIGITS-1 down to i is 0. Digit 0 is never suppressed, so a zero value shows a single "0".
- BCD codes 10–15 are passed through unchanged to `codigo`; the decoder renders them as its default pattern (dash).
- N_DIGITS=1: every GUARD→SHOW transition is a frame boundary.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - `state`=GUARD, `idx`=N_DIGITS-1, `cnt`=0.
  - `disp`=0, `shadow`=0, `pending`=0.
  - Outputs: `anodo`=0, `codigo`=0, `ready`=1, `frame`=0.
- After release, the first frame boundary occurs GUARD cycles later. Digit 0 is lit on cycle GUARD, counting the first edge after release as cycle 0.
- Each digit slot lasts DIV+GUARD cycles; a frame lasts N_DIGITS·(DIV+GUARD) cycles.
- Worst-case latency from a transfer to the new value being visible is one frame + 1 cycle.
- Reset asserted mid-frame or with a pending value discards `shadow`/`pending` immediately; nothing partial is displayed.
- `anodo` is never multi-hot, and is all-zero for at least GUARD cycles between any two lit digits.

## Test plan
- Reset sequence (N_DIGITS=4, DIV=4, GUARD=1): hold `rst_n` low, then release → during reset `anodo`=0000, `codigo`=0, `ready`=1. One cycle after release, `frame`=1 and `anodo`=0001. The scan then runs 0001×4, 0000×1, 0010×4, and so on; the pattern repeats every 20 cycles.
- Load 16'h1234 with `load`=1 for one cycle while `ready`=1 → `ready`=0 on the next cycle. At the next `frame` pulse: `codigo`=4 with `anodo`=0001, then 3/0010, 2/0100, 1/1000. `ready`=1 again from the frame cycle.
- Second `load` (16'h9999) while `ready`=0 → ignored; the display shows 1234 after the commit.
- `load` asserted in the same cycle as the GUARD→SHOW edge to digit 0 → the old value shows for that whole frame; the new value first appears at the following `frame` pulse.
- `blank_lz`=1 with value 16'h0050 → digits 3 and 2 have `anodo`=0 in their slots; digits 1 and 0 are lit with codes 5 and 0. With value 16'h0000, only digit 0 is lit, showing 0.
- Reset pulse mid-frame with `pending`=1 → `anodo`=0 immediately (asynchronous), `ready`=1, and after release the display shows 0000.
